// File: rtl/nn_layer_engine.sv
// nn_layer_engine: time-multiplexed fully-connected layer.
// One signed MAC per cycle evaluates N_NEURON neurons over N_IN inputs.
// Weights/biases stream in over cfg_*, samples over in_*, and saturated,
// activated results stream out over out_*.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cfg_start               begin parameter load (IDLE only)
//   cfg_valid/data/ready    parameter words: per neuron w[0..N_IN-1], then bias
//   in_valid/data/ready     input samples, slot 0..N_IN-1
//   act_mode                0=step 1=ReLU 2,3=linear (captured on entry to MAC)
//   out_valid/data/idx/ready  result stream, neuron 0 first
//   params_ok               complete parameter set loaded
//   busy                    high in PARAM, MAC, OUT
module nn_layer_engine #(
  parameter  int N_IN     = 4,
  parameter  int N_NEURON = 4,
  parameter  int W        = 8,
  parameter  int FRAC     = 4,
  parameter  int ACC_W    = 20,
  localparam int IW       = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic          cfg_valid,
  input  logic [W-1:0]  cfg_data,
  output logic          cfg_ready,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  input  logic [1:0]    act_mode,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_idx,
  input  logic          out_ready,
  output logic          params_ok,
  output logic          busy
);

  localparam int NP = N_NEURON * (N_IN + 1);       // words in parameter memory
  localparam int AW = $clog2(NP);
  localparam int XW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int SW = $clog2(N_IN + 1);            // MAC step 0..N_IN
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2 ** (W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(2 ** (W - 1)));

  typedef enum logic [2:0] {S_IDLE, S_PARAM, S_INPUT, S_MAC, S_OUT} state_t;
  state_t state, nstate;

  // Parameter memory keeps load order: neuron n occupies n*(N_IN+1) ..
  // n*(N_IN+1)+N_IN with the bias last.
  logic [W-1:0]  wmem [NP];
  logic [W-1:0]  xbuf [N_IN];
  logic [W-1:0]  obuf [N_NEURON];
  logic [AW-1:0] pcnt, base, addr;
  logic [XW-1:0] in_cnt;
  logic [SW-1:0] scnt, sm1;
  logic [IW-1:0] ncnt, k;
  logic [1:0]    mode;
  logic signed [ACC_W-1:0] acc, acc_nxt, r;
  logic signed [2*W-1:0]   prod;
  logic [W-1:0]  rsat, act;
  logic cfg_acc, in_acc, out_acc, nrn_last, mac_enter;

  assign cfg_acc   = cfg_valid & cfg_ready;
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;
  assign nrn_last  = (scnt == SW'(N_IN));
  assign mac_enter = (nstate == S_MAC) && (state != S_MAC);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate    = state;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_idx   = k;
    out_data  = obuf[k];
    case (state)
      S_IDLE: begin
        // cfg_start takes priority over a waiting sample
        in_ready = params_ok && !cfg_start;
        if (cfg_start) nstate = S_PARAM;
        else if (in_valid && params_ok) nstate = (N_IN == 1) ? S_MAC : S_INPUT;
      end
      S_PARAM: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        if (cfg_valid && pcnt == AW'(NP - 1)) nstate = S_IDLE;
      end
      S_INPUT: begin
        in_ready = 1'b1;
        if (in_valid && in_cnt == XW'(N_IN - 1)) nstate = S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (nrn_last && ncnt == IW'(N_NEURON - 1)) nstate = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && k == IW'(N_NEURON - 1)) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Step 0 of a neuron reads its bias, step s>0 reads w[n][s-1] and x[s-1].
  always_comb begin
    sm1  = scnt - 1'b1;
    addr = (scnt == '0) ? base + AW'(N_IN) : base + AW'(sm1);
    prod = $signed(xbuf[sm1[XW-1:0]]) * $signed(wmem[addr]);
    if (scnt == '0) acc_nxt = ACC_W'($signed(wmem[addr])) <<< FRAC;
    else            acc_nxt = acc + ACC_W'(prod);
    r = acc_nxt >>> FRAC;
    if (r > MAXV)      rsat = MAXV[W-1:0];
    else if (r < MINV) rsat = MINV[W-1:0];
    else               rsat = r[W-1:0];
    case (mode)
      2'd0:    act = (!acc_nxt[ACC_W-1] && acc_nxt != '0) ? W'(1) : '0;
      2'd1:    act = rsat[W-1] ? '0 : rsat;
      default: act = rsat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NP; i++)       wmem[i] <= '0;
      for (int i = 0; i < N_IN; i++)     xbuf[i] <= '0;
      for (int i = 0; i < N_NEURON; i++) obuf[i] <= '0;
      pcnt      <= '0;
      base      <= '0;
      in_cnt    <= '0;
      scnt      <= '0;
      ncnt      <= '0;
      k         <= '0;
      mode      <= '0;
      acc       <= '0;
      params_ok <= 1'b0;
    end else begin
      if (mac_enter) begin
        mode <= act_mode;
        scnt <= '0;
        ncnt <= '0;
        base <= '0;
        k    <= '0;
      end
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            pcnt      <= '0;
            params_ok <= 1'b0;
          end else if (in_acc) begin
            xbuf[0] <= in_data;
            in_cnt  <= XW'(1);
          end
        end
        S_PARAM: begin
          if (cfg_acc) begin
            wmem[pcnt] <= cfg_data;
            pcnt       <= pcnt + 1'b1;
            if (pcnt == AW'(NP - 1)) params_ok <= 1'b1;
          end
        end
        S_INPUT: begin
          if (in_acc) begin
            xbuf[in_cnt] <= in_data;
            in_cnt       <= in_cnt + 1'b1;
          end
        end
        S_MAC: begin
          acc <= acc_nxt;
          if (nrn_last) begin
            obuf[ncnt] <= act;
            scnt       <= '0;
            ncnt       <= ncnt + 1'b1;
            base       <= base + AW'(N_IN + 1);
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        S_OUT: if (out_acc) k <= k + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_engine.sv
// Bench for nn_layer_engine (N_IN=4, N_NEURON=4, W=8, FRAC=4).
// Directed steps plus randomized inferences; expected results come from an
// integer-arithmetic model of the layer equations.
module tb_nn_layer_engine;
  localparam int N_IN = 4, N_NEURON = 4, W = 8, FRAC = 4;
  localparam int LAT = N_NEURON * (N_IN + 1) + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_start = 1'b0, cfg_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] cfg_data = '0, in_data = '0;
  logic [1:0] act_mode = 2'd2;
  logic cfg_ready, in_ready, out_valid, params_ok, busy;
  logic [7:0] out_data;
  logic [1:0] out_idx;

  int vectors = 0, miscompares = 0;
  int wm [N_NEURON][N_IN];
  int bm [N_NEURON];
  int xm [N_IN];

  nn_layer_engine #(.N_IN(N_IN), .N_NEURON(N_NEURON), .W(W), .FRAC(FRAC), .ACC_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .act_mode(act_mode),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_ready(out_ready), .params_ok(params_ok), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Layer equation in plain integers: acc = b*2^FRAC + sum(x*w).
  function automatic logic [7:0] model(input int n, input int mode);
    int acc;
    int r;
    acc = bm[n] * (1 << FRAC);
    for (int i = 0; i < N_IN; i++) acc += xm[i] * wm[n][i];
    r = acc >>> FRAC;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    case (mode)
      0:       return (acc > 0) ? 8'd1 : 8'd0;
      1:       return (r < 0) ? 8'd0 : 8'(r);
      default: return 8'(r);
    endcase
  endfunction

  function automatic int rnd8();
    logic [7:0] b;
    b = 8'($urandom);
    return int'($signed(b));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    in_valid = 1'b1;
    #1;
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_data"},  32'(out_data), 0);
    check({tag, "_out_idx"},   32'(out_idx), 0);
    check({tag, "_params_ok"}, 32'(params_ok), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 0);
    check({tag, "_in_ready"},  32'(in_ready), 0);
    in_valid = 1'b0;
  endtask

  task automatic send_cfg(input int v);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_data  = 8'(v);
    #1;
    while (!cfg_ready && n < 50) begin tick(); n++; end
    check("cfg_ready_wait", 32'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic load_words();
    for (int n = 0; n < N_NEURON; n++) begin
      for (int i = 0; i < N_IN; i++) send_cfg(wm[n][i]);
      send_cfg(bm[n]);
    end
  endtask

  task automatic load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    load_words();
    check("params_ok_after_load", 32'(params_ok), 1);
    check("busy_after_load", 32'(busy), 0);
  endtask

  task automatic send_in(input int v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = 8'(v);
    #1;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("in_ready_wait", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_all(input int mode);
    act_mode = 2'(mode);
    for (int i = 0; i < N_IN; i++) send_in(xm[i]);
  endtask

  // Entered one cycle after the accepting cycle; counts until out_valid.
  task automatic wait_out(input int exp);
    int c = 1;
    while (!out_valid && c < 200) begin tick(); c++; end
    check("latency", 32'(c), 32'(exp));
  endtask

  // bp: 0 always ready, 1 toggling ready, 2 random ready
  task automatic collect(input int mode, input int bp);
    for (int k = 0; k < N_NEURON; k++) begin
      int n = 0;
      logic [7:0] e;
      e = model(k, mode);
      out_ready = (bp == 0) ? 1'b1 : (bp == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      while (!(out_valid && out_ready) && n < 100) begin
        if (out_valid) begin
          check("stall_idx", 32'(out_idx), 32'(k));
          check("stall_data", 32'(out_data), 32'(e));
        end
        tick();
        out_ready = (bp == 0) ? 1'b1 : (bp == 1) ? ~out_ready : 1'($urandom_range(0, 1));
        n++;
      end
      check("out_valid", 32'(out_valid), 1);
      check("out_idx", 32'(out_idx), 32'(k));
      check("out_data", 32'(out_data), 32'(e));
      tick();
    end
    out_ready = 1'b0;
    check("out_valid_after", 32'(out_valid), 0);
    check("busy_after", 32'(busy), 0);
  endtask

  task automatic infer(input int mode, input int bp);
    send_all(mode);
    wait_out(LAT);
    collect(mode, bp);
  endtask

  task automatic set_all(input int w, input int b);
    for (int n = 0; n < N_NEURON; n++) begin
      for (int i = 0; i < N_IN; i++) wm[n][i] = w;
      bm[n] = b;
    end
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check_reset_state("reset");

    // samples offered before any load are refused
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("in_ready_no_params", 32'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;

    // unity weights, zero bias, inputs 1..4 -> 10
    set_all(16, 0);
    load();
    for (int i = 0; i < N_IN; i++) xm[i] = i + 1;
    infer(2, 0);

    // bias 5 on neuron 2 -> 15
    bm[2] = 5;
    load();
    infer(2, 0);

    // negative weights across modes; parameters persist between inferences
    set_all(-16, 0);
    load();
    infer(1, 0);
    infer(2, 0);
    infer(0, 0);
    infer(3, 0);

    // saturation both ways
    set_all(127, 127);
    load();
    for (int i = 0; i < N_IN; i++) xm[i] = 127;
    infer(2, 0);
    for (int i = 0; i < N_IN; i++) xm[i] = -128;
    infer(2, 0);

    // backpressure: hold ten cycles, then toggle ready
    for (int n = 0; n < N_NEURON; n++) begin
      for (int i = 0; i < N_IN; i++) wm[n][i] = rnd8();
      bm[n] = rnd8();
    end
    load();
    for (int i = 0; i < N_IN; i++) xm[i] = rnd8();
    send_all(2);
    wait_out(LAT);
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("hold_idx", 32'(out_idx), 0);
      check("hold_data", 32'(out_data), 32'(model(0, 2)));
      tick();
    end
    collect(2, 1);

    // cfg_start together with in_valid in IDLE: PARAM wins, sample refused
    in_valid  = 1'b1;
    in_data   = 8'h55;
    cfg_start = 1'b1;
    #1;
    check("in_ready_vs_start", 32'(in_ready), 0);
    tick();
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    check("param_entered_cfg_ready", 32'(cfg_ready), 1);
    check("param_entered_params_ok", 32'(params_ok), 0);
    check("param_entered_in_ready", 32'(in_ready), 0);
    for (int n = 0; n < N_NEURON; n++) begin
      for (int i = 0; i < N_IN; i++) wm[n][i] = rnd8();
      bm[n] = rnd8();
    end
    load_words();
    check("params_ok_reload", 32'(params_ok), 1);
    for (int i = 0; i < N_IN; i++) xm[i] = rnd8();
    infer(1, 0);

    // cfg_start during MAC is ignored
    for (int i = 0; i < N_IN; i++) xm[i] = rnd8();
    send_all(2);
    tick(); tick(); tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("mac_start_cfg_ready", 32'(cfg_ready), 0);
    check("mac_start_params_ok", 32'(params_ok), 1);
    check("mac_start_busy", 32'(busy), 1);
    wait_out(LAT - 4);
    collect(2, 0);

    // reset mid-MAC
    send_all(2);
    tick(); tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state("rst_mac");

    // reset mid-PARAM
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int j = 0; j < 7; j++) send_cfg(rnd8());
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state("rst_param");

    // randomized inferences with random backpressure
    for (int it = 0; it < 8; it++) begin
      if (it % 2 == 0) begin
        for (int n = 0; n < N_NEURON; n++) begin
          for (int i = 0; i < N_IN; i++) wm[n][i] = rnd8();
          bm[n] = rnd8();
        end
        load();
      end
      for (int i = 0; i < N_IN; i++) xm[i] = rnd8();
      infer(int'($urandom_range(0, 3)), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
